// File: rtl/vga_pkg.sv
// Shared timing types, reset-time 640x480 defaults and timing-field helpers
// for the video timing generator.
package vga_pkg;

   localparam int VGA_CW = 11;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Sums carry two guard bits so a full 4-field total never overflows.
   localparam logic [VGA_CW+1:0] SUM_ONE  = {{(VGA_CW+1){1'b0}}, 1'b1};
   localparam logic [VGA_CW+1:0] AXIS_MAX = {2'b01, {VGA_CW{1'b0}}};

   typedef struct packed {
      logic [VGA_CW-1:0] active;
      logic [VGA_CW-1:0] fp;
      logic [VGA_CW-1:0] sync;
      logic [VGA_CW-1:0] bp;
   } axis_timing_t;

   typedef struct packed {
      axis_timing_t h;
      axis_timing_t v;
      logic [1:0]   pol;
   } vga_timing_t;

   function automatic logic [VGA_CW+1:0] axis_total(input axis_timing_t t);
      return {2'b00, t.active} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
   endfunction

   function automatic logic axis_valid(input axis_timing_t t);
      return (t.active != '0) && (t.sync != '0) && (axis_total(t) <= AXIS_MAX);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter over [0, total-1] plus combinational
// wrap, sync-window and active-region flags for the current position.
module vga_axis_counter
   import vga_pkg::*;
(
   input  logic              clk_pix,
   input  logic              rst_pix,
   input  logic              step,
   input  axis_timing_t      tim,
   output logic [VGA_CW-1:0] pos,
   output logic              wrap,
   output logic              in_sync,
   output logic              in_active
);

   logic [VGA_CW+1:0] pos_w;
   logic [VGA_CW+1:0] total;
   logic [VGA_CW+1:0] sync_lo;
   logic [VGA_CW+1:0] sync_hi;

   assign pos_w   = {2'b00, pos};
   assign total   = axis_total(tim);
   assign sync_lo = {2'b00, tim.active} + {2'b00, tim.fp};
   assign sync_hi = sync_lo + {2'b00, tim.sync};

   assign wrap      = step && (pos_w == (total - SUM_ONE));
   assign in_sync   = (pos_w >= sync_lo) && (pos_w < sync_hi);
   assign in_active = (pos_w < {2'b00, tim.active});

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         pos <= '0;
      end else if (wrap) begin
         pos <= '0;
      end else if (step) begin
         pos <= pos + VGA_CW'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: runtime-reloadable h/v timing applied at frame
// boundaries, with registered coordinates, syncs, data enable and strobes.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int CW       = VGA_CW,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0
) (
   input  logic            clk_pix,
   input  logic            rst_pix,
   input  logic [4*CW-1:0] cfg_h,
   input  logic [4*CW-1:0] cfg_v,
   input  logic [1:0]      cfg_pol,
   input  logic            cfg_load,
   output logic            cfg_pending,
   output logic            cfg_err,
   output logic [CW-1:0]   sx,
   output logic [CW-1:0]   sy,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic            line_start,
   output logic            frame_start,
   output logic            line_req,
   output logic [CW-1:0]   line_req_y,
   output logic            vblank_start,
   output logic [15:0]     frame_cnt
);

   localparam axis_timing_t RST_H = '{
      active: VGA_CW'(H_ACTIVE),
      fp:     VGA_CW'(H_FP),
      sync:   VGA_CW'(H_SYNC),
      bp:     VGA_CW'(H_BP)
   };
   localparam axis_timing_t RST_V = '{
      active: VGA_CW'(V_ACTIVE),
      fp:     VGA_CW'(V_FP),
      sync:   VGA_CW'(V_SYNC),
      bp:     VGA_CW'(V_BP)
   };
   localparam vga_timing_t RST_CFG = '{h: RST_H, v: RST_V, pol: {V_POL, H_POL}};

   vga_timing_t       live;
   vga_timing_t       pend;
   axis_timing_t      load_h;
   axis_timing_t      load_v;
   logic              load_ok;

   logic [VGA_CW-1:0] h;
   logic [VGA_CW-1:0] v;
   logic              h_wrap;
   logic              v_wrap;
   logic              h_sync;
   logic              v_sync;
   logic              h_act;
   logic              v_act;
   logic              frame_end;

   logic              v_last;
   logic [VGA_CW-1:0] v_next;
   logic              line_req_now;

   assign load_h  = cfg_h;
   assign load_v  = cfg_v;
   assign load_ok = axis_valid(load_h) && axis_valid(load_v);

   vga_axis_counter u_h_axis (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .step      (1'b1),
      .tim       (live.h),
      .pos       (h),
      .wrap      (h_wrap),
      .in_sync   (h_sync),
      .in_active (h_act)
   );

   vga_axis_counter u_v_axis (
      .clk_pix   (clk_pix),
      .rst_pix   (rst_pix),
      .step      (h_wrap),
      .tim       (live.v),
      .pos       (v),
      .wrap      (v_wrap),
      .in_sync   (v_sync),
      .in_active (v_act)
   );

   // v only wraps on an h wrap, so this is exactly the last pixel of the frame.
   assign frame_end = v_wrap;

   // cfg_load is a bare strobe with no ready: every asserted cycle is one
   // capture attempt, judged on the cfg_* values present in that cycle.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         live        <= RST_CFG;
         pend        <= RST_CFG;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= cfg_load && !load_ok;
         if (frame_end && cfg_pending) begin
            live <= pend;
         end
         // A capture in the boundary cycle survives as pending for the next frame.
         if (cfg_load && load_ok) begin
            pend        <= '{h: load_h, v: load_v, pol: cfg_pol};
            cfg_pending <= 1'b1;
         end else if (frame_end) begin
            cfg_pending <= 1'b0;
         end
      end
   end

   assign v_last       = ({2'b00, v} == (axis_total(live.v) - SUM_ONE));
   assign v_next       = v_last ? '0 : (v + VGA_CW'(1));
   assign line_req_now = (h == live.h.active) && (v_next < live.v.active);

   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         sx           <= '0;
         sy           <= '0;
         hsync        <= ~H_POL;
         vsync        <= ~V_POL;
         de           <= 1'b0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         line_req     <= 1'b0;
         line_req_y   <= '0;
         vblank_start <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         sx           <= h;
         sy           <= v;
         hsync        <= h_sync ? live.pol[0] : ~live.pol[0];
         vsync        <= v_sync ? live.pol[1] : ~live.pol[1];
         de           <= h_act && v_act;
         line_start   <= (h == '0);
         frame_start  <= (h == '0) && (v == '0);
         vblank_start <= (h == '0) && (v == live.v.active);
         line_req     <= line_req_now;
         if (line_req_now) begin
            line_req_y <= v_next;
         end
         if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen against a position-arithmetic reference
// model; small reset-time timing keeps whole frames short.
module tb_vga_timing_gen;

   localparam int RH_A = 32, RH_F = 4, RH_S = 8, RH_B = 6;
   localparam int RV_A = 12, RV_F = 2, RV_S = 2, RV_B = 3;

   typedef struct packed {
      logic [10:0] sx;
      logic [10:0] sy;
      logic        hsync;
      logic        vsync;
      logic        de;
      logic        line_start;
      logic        frame_start;
      logic        line_req;
      logic [10:0] line_req_y;
      logic        vblank_start;
      logic        cfg_pending;
      logic        cfg_err;
      logic [15:0] frame_cnt;
   } exp_t;

   logic        clk_pix = 1'b0;
   logic        rst_pix = 1'b1;
   logic [43:0] cfg_h = '0;
   logic [43:0] cfg_v = '0;
   logic [1:0]  cfg_pol = '0;
   logic        cfg_load = 1'b0;
   logic        cfg_pending, cfg_err;
   logic [10:0] sx, sy, line_req_y;
   logic        hsync, vsync, de, line_start, frame_start, line_req, vblank_start;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   exp_t        exp_q[$];
   logic [43:0] live_hv, live_vv, pend_hv, pend_vv;
   logic [1:0]  live_pol, pend_pol;
   logic        m_pend;
   int          m_cnt;
   logic [15:0] m_frames;
   logic [10:0] m_lry;

   vga_timing_gen #(
      .H_ACTIVE (RH_A), .H_FP (RH_F), .H_SYNC (RH_S), .H_BP (RH_B),
      .V_ACTIVE (RV_A), .V_FP (RV_F), .V_SYNC (RV_S), .V_BP (RV_B),
      .H_POL    (1'b0), .V_POL (1'b0)
   ) dut (
      .clk_pix      (clk_pix),
      .rst_pix      (rst_pix),
      .cfg_h        (cfg_h),
      .cfg_v        (cfg_v),
      .cfg_pol      (cfg_pol),
      .cfg_load     (cfg_load),
      .cfg_pending  (cfg_pending),
      .cfg_err      (cfg_err),
      .sx           (sx),
      .sy           (sy),
      .hsync        (hsync),
      .vsync        (vsync),
      .de           (de),
      .line_start   (line_start),
      .frame_start  (frame_start),
      .line_req     (line_req),
      .line_req_y   (line_req_y),
      .vblank_start (vblank_start),
      .frame_cnt    (frame_cnt)
   );

   // clock / reset
   always #5 clk_pix = ~clk_pix;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [43:0] mk(input int a, input int f, input int s, input int b);
      return {11'(a), 11'(f), 11'(s), 11'(b)};
   endfunction

   function automatic int fld(input logic [43:0] c, input int i);
      return int'(c[43-11*i -: 11]);
   endfunction

   function automatic int tot(input logic [43:0] c);
      return fld(c, 0) + fld(c, 1) + fld(c, 2) + fld(c, 3);
   endfunction

   function automatic bit cfg_ok(input logic [43:0] c);
      return (fld(c, 0) != 0) && (fld(c, 2) != 0) && (tot(c) <= 2048);
   endfunction

   function automatic int cur_h();
      return m_cnt % tot(live_hv);
   endfunction

   function automatic int cur_v();
      return m_cnt / tot(live_hv);
   endfunction

   task automatic model_reset();
      live_hv  = mk(RH_A, RH_F, RH_S, RH_B);
      live_vv  = mk(RV_A, RV_F, RV_S, RV_B);
      live_pol = 2'b00;
      pend_hv  = live_hv;
      pend_vv  = live_vv;
      pend_pol = live_pol;
      m_pend   = 1'b0;
      m_cnt    = 0;
      m_frames = '0;
      m_lry    = '0;
      exp_q.delete();
   endtask

   // Expected outputs for the position the counters held in the last cycle.
   task automatic model_step();
      exp_t e;
      int   ht, vt, h, v, lo, nxt;
      bit   bnd, ok;
      ht = tot(live_hv);
      vt = tot(live_vv);
      h  = m_cnt % ht;
      v  = m_cnt / ht;
      e.sx = 11'(h);
      e.sy = 11'(v);
      lo = fld(live_hv, 0) + fld(live_hv, 1);
      e.hsync = (h >= lo && h < lo + fld(live_hv, 2)) ? live_pol[0] : ~live_pol[0];
      lo = fld(live_vv, 0) + fld(live_vv, 1);
      e.vsync = (v >= lo && v < lo + fld(live_vv, 2)) ? live_pol[1] : ~live_pol[1];
      e.de           = (h < fld(live_hv, 0)) && (v < fld(live_vv, 0));
      e.line_start   = (h == 0);
      e.frame_start  = (m_cnt == 0);
      e.vblank_start = (h == 0) && (v == fld(live_vv, 0));
      nxt = (v + 1) % vt;
      e.line_req = (h == fld(live_hv, 0)) && (nxt < fld(live_vv, 0));
      if (e.line_req) m_lry = 11'(nxt);
      e.line_req_y = m_lry;
      ok = cfg_ok(cfg_h) && cfg_ok(cfg_v);
      e.cfg_err = cfg_load && !ok;
      bnd = (m_cnt == ht * vt - 1);
      if (bnd) begin
         if (m_pend) begin
            live_hv  = pend_hv;
            live_vv  = pend_vv;
            live_pol = pend_pol;
         end
         m_frames = m_frames + 16'd1;
         m_cnt    = 0;
      end else begin
         m_cnt++;
      end
      if (cfg_load && ok) begin
         pend_hv  = cfg_h;
         pend_vv  = cfg_v;
         pend_pol = cfg_pol;
         m_pend   = 1'b1;
      end else if (bnd) begin
         m_pend = 1'b0;
      end
      e.cfg_pending = m_pend;
      e.frame_cnt   = m_frames;
      exp_q.push_back(e);
   endtask

   // scoreboard
   always @(negedge clk_pix) begin
      if (chk_en) begin
         exp_t e;
         model_step();
         e = exp_q.pop_front();
         check("sx", 32'(sx), 32'(e.sx));
         check("sy", 32'(sy), 32'(e.sy));
         check("hsync", 32'(hsync), 32'(e.hsync));
         check("vsync", 32'(vsync), 32'(e.vsync));
         check("de", 32'(de), 32'(e.de));
         check("line_start", 32'(line_start), 32'(e.line_start));
         check("frame_start", 32'(frame_start), 32'(e.frame_start));
         check("line_req", 32'(line_req), 32'(e.line_req));
         check("line_req_y", 32'(line_req_y), 32'(e.line_req_y));
         check("vblank_start", 32'(vblank_start), 32'(e.vblank_start));
         check("cfg_pending", 32'(cfg_pending), 32'(e.cfg_pending));
         check("cfg_err", 32'(cfg_err), 32'(e.cfg_err));
         check("frame_cnt", 32'(frame_cnt), 32'(e.frame_cnt));
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk_pix);
      #1;
   endtask

   task automatic do_load(input logic [43:0] ch, input logic [43:0] cv, input logic [1:0] pl);
      cfg_h    = ch;
      cfg_v    = cv;
      cfg_pol  = pl;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic wait_pos(input int h, input int v, input int limit);
      int n = 0;
      while (!(cur_h() == h && cur_v() == v) && n < limit) begin
         tick();
         n++;
      end
      check("wait_reached", 32'(cur_h() == h && cur_v() == v), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sx"}, 32'(sx), 0);
      check({tag, "_sy"}, 32'(sy), 0);
      check({tag, "_de"}, 32'(de), 0);
      check({tag, "_hsync"}, 32'(hsync), 1);
      check({tag, "_vsync"}, 32'(vsync), 1);
      check({tag, "_strobes"}, 32'({line_start, frame_start, line_req, vblank_start}), 0);
      check({tag, "_pend"}, 32'(cfg_pending), 0);
      check({tag, "_err"}, 32'(cfg_err), 0);
      check({tag, "_fcnt"}, 32'(frame_cnt), 0);
      check({tag, "_lry"}, 32'(line_req_y), 0);
   endtask

   task automatic release_reset();
      rst_pix = 1'b0;
      model_reset();
      chk_en = 1'b1;
   endtask

   initial begin
      int          fs_seen, last_fs, de_n, hmin, hmax, vmin, vmax, nfs, nhs, nvs;
      logic [10:0] got_y[$];
      int          exp_y[4] = '{1, 2, 3, 0};
      logic [43:0] ch, cv;
      logic [1:0]  pl;
      int          sel;

      repeat (2) tick();
      check_reset_vals("rst");
      release_reset();

      // Reset-time timing over two whole frames: lengths, de totals, sync windows.
      fs_seen = 0; last_fs = 0; de_n = 0;
      hmin = 9999; hmax = -1; vmin = 9999; vmax = -1;
      for (int i = 0; i < 4000 && fs_seen < 3; i++) begin
         tick();
         if (frame_start) begin
            if (fs_seen > 0) begin
               check("frame_len", 32'(i - last_fs), 32'((RH_A + RH_F + RH_S + RH_B) * (RV_A + RV_F + RV_S + RV_B)));
               check("de_per_frame", 32'(de_n), 32'(RH_A * RV_A));
            end
            fs_seen++;
            last_fs = i;
            de_n = 0;
         end
         if (de) de_n++;
         if (!hsync) begin
            if (int'(sx) < hmin) hmin = int'(sx);
            if (int'(sx) > hmax) hmax = int'(sx);
         end
         if (!vsync) begin
            if (int'(sy) < vmin) vmin = int'(sy);
            if (int'(sy) > vmax) vmax = int'(sy);
         end
      end
      check("frame_starts", 32'(fs_seen), 3);
      check("hsync_lo_min", 32'(hmin), 32'(RH_A + RH_F));
      check("hsync_lo_max", 32'(hmax), 32'(RH_A + RH_F + RH_S - 1));
      check("vsync_lo_min", 32'(vmin), 32'(RV_A + RV_F));
      check("vsync_lo_max", 32'(vmax), 32'(RV_A + RV_F + RV_S - 1));

      // Tiny config loaded mid-frame; check its first whole frame.
      wait_pos(10, 5, 2000);
      do_load(mk(8, 2, 2, 2), mk(4, 1, 1, 1), 2'b11);
      check("tiny_pending", 32'(cfg_pending), 1);
      wait_pos(0, 0, 2000);
      nfs = 0; nhs = 0; nvs = 0;
      for (int i = 0; i < 98; i++) begin
         tick();
         if (frame_start) nfs++;
         if (hsync) nhs++;
         if (vsync) nvs++;
         if (line_req) got_y.push_back(line_req_y);
      end
      check("tiny_fs_count", 32'(nfs), 1);
      check("tiny_hsync_hi", 32'(nhs), 14);
      check("tiny_vsync_hi", 32'(nvs), 14);
      check("tiny_nreq", 32'(got_y.size()), 4);
      for (int i = 0; i < 4 && i < got_y.size(); i++) check("tiny_req_y", 32'(got_y[i]), 32'(exp_y[i]));
      tick();
      check("tiny_frame_len", 32'(frame_start), 1);

      // Rejected loads, an exact 2048 total, then overwrite before the boundary.
      wait_pos(1, 0, 500);
      do_load(mk(8, 2, 0, 2), mk(4, 1, 1, 1), 2'b00);
      check("err_pulse", 32'(cfg_err), 1);
      check("err_pend", 32'(cfg_pending), 0);
      tick();
      check("err_width", 32'(cfg_err), 0);
      do_load(mk(2000, 40, 8, 8), mk(4, 1, 1, 1), 2'b00);
      check("err_ht", 32'(cfg_err), 1);
      do_load(mk(2000, 40, 4, 4), mk(1, 0, 1, 0), 2'b01);
      check("ht2048_ok", 32'({cfg_err, cfg_pending}), 1);
      do_load(mk(4, 1, 1, 1), mk(2047, 1, 1, 0), 2'b00);
      check("err_vt_pend", 32'({cfg_err, cfg_pending}), 3);
      do_load(mk(6, 1, 2, 1), mk(3, 1, 1, 1), 2'b10);
      repeat (300) tick();

      // Load in the boundary cycle, then back-to-back A then B.
      wait_pos(tot(live_hv) - 1, tot(live_vv) - 1, 2000);
      do_load(mk(5, 0, 1, 2), mk(2, 1, 1, 0), 2'b01);
      check("bnd_pending", 32'(cfg_pending), 1);
      repeat (200) tick();
      wait_pos(3, 1, 2000);
      do_load(mk(9, 1, 3, 1), mk(5, 1, 2, 1), 2'b11);
      do_load(mk(7, 2, 1, 0), mk(3, 0, 1, 2), 2'b10);
      repeat (300) tick();

      // Asynchronous reset mid-line with a capture pending.
      wait_pos(5, 2, 2000);
      do_load(mk(10, 1, 1, 1), mk(3, 1, 1, 1), 2'b11);
      #2;
      rst_pix = 1'b1;
      chk_en  = 1'b0;
      #1;
      check_reset_vals("async_rst");
      repeat (2) tick();
      release_reset();
      repeat (1000) tick();

      // Randomised loads, some invalid, some landing on the frame boundary.
      for (int it = 0; it < 60; it++) begin
         ch  = mk($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3));
         cv  = mk($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(1, 2), $urandom_range(0, 2));
         pl  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         if (sel == 0) ch = mk($urandom_range(1, 12), 1, 0, 1);
         if (sel == 1) cv = mk(0, 1, 1, 1);
         if (sel == 2) ch = mk(2047, 1, 1, 0);
         if (sel == 3) cv = mk(1000, 1000, 40, 9);
         if ($urandom_range(0, 3) == 0) wait_pos(tot(live_hv) - 1, tot(live_vv) - 1, 5000);
         else repeat ($urandom_range(0, 150)) tick();
         do_load(ch, cv, pl);
      end
      repeat (600) tick();

      // frame_cnt wrap.
      wait_pos(1, 0, 5000);
      force dut.frame_cnt = 16'hFFFF;
      m_frames = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      wait_pos(0, 0, 5000);
      check("fcnt_wrap", 32'(frame_cnt), 0);
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
